// File: rtl/sha3_padder_stream.sv
// SHA-3 input padder: packs W-bit big-endian words into rate blocks
// and closes each message with the domain suffix and pad10*1.
module sha3_padder_stream #(
  parameter int W = 32,
  parameter int RATE_WORDS = 18,
  parameter logic [7:0] SUFFIX = 8'h06,
  localparam int NB = W / 8,
  localparam int BW = (NB > 1) ? $clog2(NB) : 1,
  localparam int CW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [W-1:0]            in,
  input  logic                    in_ready,
  input  logic                    is_last,
  input  logic [BW-1:0]           byte_num,
  output logic                    accept,
  output logic                    buffer_full,
  output logic [RATE_WORDS*W-1:0] out,
  output logic                    out_last,
  input  logic                    f_ack
);

  typedef enum logic [1:0] {
    ABSORB,
    PAD,
    HOLD
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(RATE_WORDS - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          at_end;
  logic          we;
  logic [W-1:0]  last_word;
  logic [W-1:0]  pad_word;
  logic [W-1:0]  wdata;

  assign at_end = (cnt == LAST);
  assign accept = in_ready & ~reset & (state == ABSORB) & ~buffer_full;
  assign we     = accept | (state == PAD);

  // keep byte_num bytes, then the suffix, then zeros; the rate's final
  // byte also carries the closing 1 bit of pad10*1
  always_comb begin
    last_word = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < 32'(byte_num))
        last_word[W-1-8*b -: 8] = in[W-1-8*b -: 8];
      else if (b == 32'(byte_num))
        last_word[W-1-8*b -: 8] = SUFFIX;
    end
    if (at_end)
      last_word[7:0] = last_word[7:0] | 8'h80;
  end

  assign pad_word = at_end ? W'(8'h80) : '0;

  always_comb begin
    wdata = in;
    if (state == PAD)
      wdata = pad_word;
    else if (is_last)
      wdata = last_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ABSORB;
      cnt         <= '0;
      out         <= '0;
      buffer_full <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      if (we) begin
        for (int i = 0; i < RATE_WORDS; i++) begin
          if (cnt == CW'(i))
            out[(RATE_WORDS-1-i)*W +: W] <= wdata;
        end
      end
      unique case (state)
        ABSORB: begin
          if (accept) begin
            if (at_end) begin
              cnt         <= '0;
              buffer_full <= 1'b1;
              out_last    <= is_last;
              state       <= HOLD;
            end else begin
              cnt <= cnt + CW'(1);
              if (is_last)
                state <= PAD;
            end
          end
        end
        PAD: begin
          if (at_end) begin
            cnt         <= '0;
            buffer_full <= 1'b1;
            out_last    <= 1'b1;
            state       <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (f_ack) begin
            buffer_full <= 1'b0;
            out_last    <= 1'b0;
            cnt         <= '0;
            out         <= '0;
            state       <= ABSORB;
          end
        end
        default: state <= ABSORB;
      endcase
    end
  end

endmodule
